// File: rtl/write_buffer.sv
// Posted-write buffer between the CPU memory port and main memory.
// Writes are queued and acked at once, drained in the background; reads hit the queue first.
`ifndef MEMORY_WIDTH
`define MEMORY_WIDTH 128
`endif

module write_buffer #(
    parameter int WIDTH       = `MEMORY_WIDTH,
    parameter int DEPTH       = 4,
    parameter int OFFSET_BITS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_enable,
    input  logic                       cpu_rw,
    input  logic [31:0]                cpu_addr,
    input  logic [WIDTH-1:0]           cpu_data_in,
    output logic [WIDTH-1:0]           cpu_data_out,
    output logic                       cpu_ack,
    output logic                       mem_enable,
    output logic                       mem_rw,
    output logic [31:0]                mem_addr,
    output logic [WIDTH-1:0]           mem_data_in,
    input  logic [WIDTH-1:0]           mem_data_out,
    input  logic                       mem_ack,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TAG_W = 32 - OFFSET_BITS;

    typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, ACK} state_t;

    state_t                 state_q;
    logic [DEPTH-1:0]       valid_q;
    logic [TAG_W-1:0]       tag_q  [DEPTH];
    logic [WIDTH-1:0]       data_q [DEPTH];
    logic [PTR_W-1:0]       head_q, tail_q;
    logic [CNT_W-1:0]       count_q;
    logic                   cpu_ack_q, mem_en_q, mem_rw_q;
    logic [WIDTH-1:0]       cpu_data_q, mem_wdata_q;
    logic [31:0]            mem_addr_q;

    logic [TAG_W-1:0]       req_tag;
    logic [DEPTH-1:0]       match_vec;
    logic                   hit;
    logic [PTR_W-1:0]       hit_idx, scan_idx;
    logic                   full;
    logic                   unused_offset;

    assign req_tag       = cpu_addr[31:OFFSET_BITS];
    assign unused_offset = ^cpu_addr[OFFSET_BITS-1:0];
    assign full          = (count_q == CNT_W'(DEPTH));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match_vec[gi] = valid_q[gi] && (tag_q[gi] == req_tag);
        end
    endgenerate

    // Scan oldest to newest so the last match found is the most recent write to the line.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        scan_idx = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            scan_idx = tail_q - PTR_W'(k);
            if (match_vec[scan_idx]) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_data_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_rw_q    <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_enable && cpu_rw) begin
                        if (hit) begin
                            cpu_data_q <= data_q[hit_idx];
                            cpu_ack_q  <= 1'b1;
                            state_q    <= ACK;
                        end else begin
                            mem_en_q   <= 1'b1;
                            mem_rw_q   <= 1'b1;
                            mem_addr_q <= {req_tag, {OFFSET_BITS{1'b0}}};
                            state_q    <= MEM_RD;
                        end
                    // No drain is in flight in IDLE, so any matching entry may be coalesced.
                    end else if (cpu_enable && hit) begin
                        data_q[hit_idx] <= cpu_data_in;
                        cpu_ack_q       <= 1'b1;
                        state_q         <= ACK;
                    end else if (cpu_enable && !full) begin
                        valid_q[tail_q] <= 1'b1;
                        tag_q[tail_q]   <= req_tag;
                        data_q[tail_q]  <= cpu_data_in;
                        tail_q          <= tail_q + PTR_W'(1);
                        count_q         <= count_q + CNT_W'(1);
                        cpu_ack_q       <= 1'b1;
                        state_q         <= ACK;
                    end else if (count_q != '0) begin
                        mem_en_q    <= 1'b1;
                        mem_rw_q    <= 1'b0;
                        mem_addr_q  <= {tag_q[head_q], {OFFSET_BITS{1'b0}}};
                        mem_wdata_q <= data_q[head_q];
                        state_q     <= MEM_WR;
                    end
                end
                MEM_RD: begin
                    if (mem_ack) begin
                        cpu_data_q <= mem_data_out;
                        mem_en_q   <= 1'b0;
                        cpu_ack_q  <= 1'b1;
                        state_q    <= ACK;
                    end
                end
                MEM_WR: begin
                    if (mem_ack) begin
                        valid_q[head_q] <= 1'b0;
                        head_q          <= head_q + PTR_W'(1);
                        count_q         <= count_q - CNT_W'(1);
                        mem_en_q        <= 1'b0;
                        mem_rw_q        <= 1'b1;
                        state_q         <= IDLE;
                    end
                end
                ACK: begin
                    cpu_ack_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_ack      = cpu_ack_q;
    assign cpu_data_out = cpu_data_q;
    assign mem_enable   = mem_en_q;
    assign mem_rw       = mem_rw_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_in  = mem_wdata_q;
    assign count        = count_q;
    assign empty        = (count_q == '0);

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: queueing, forwarding, full stall, read priority,
// coalescing and reset abort.
module tb_write_buffer;
    localparam int WIDTH = 128;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             cpu_enable, cpu_rw;
    logic [31:0]      cpu_addr;
    logic [WIDTH-1:0] cpu_data_in, cpu_data_out;
    logic             cpu_ack;
    logic             mem_enable, mem_rw;
    logic [31:0]      mem_addr;
    logic [WIDTH-1:0] mem_data_in, mem_data_out;
    logic             mem_ack;
    logic [CW-1:0]    count;
    logic             empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    write_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OFFSET_BITS(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_enable(cpu_enable), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .cpu_ack(cpu_ack),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_ack(mem_ack),
        .count(count), .empty(empty)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic rw, input logic [31:0] addr, input logic [WIDTH-1:0] data);
        cpu_enable  = 1'b1;
        cpu_rw      = rw;
        cpu_addr    = addr;
        cpu_data_in = data;
        $display("txn %s addr=%08h data=%032h", rw ? "read " : "write", addr, data);
    endtask

    task automatic wait_mem(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_enable) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic drain_all(output bit ok);
        for (int i = 0; i < 60; i++) begin
            if (empty && !mem_enable) break;
            if (mem_enable) begin
                mem_ack = 1'b1;
                tick();
                mem_ack = 1'b0;
            end else begin
                tick();
            end
        end
        ok = empty && !mem_enable;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_cpu_ack got %0b want 0", cpu_ack); end
        checks++; if (cpu_data_out !== '0) begin errors++; $display("FAIL reset_cpu_data got %h want 0", cpu_data_out); end
        checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %0b want 0", mem_enable); end
        checks++; if (mem_rw !== 1'b1) begin errors++; $display("FAIL reset_mem_rw got %0b want 1", mem_rw); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        checks++; if (mem_data_in !== '0) begin errors++; $display("FAIL reset_mem_data got %h want 0", mem_data_in); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_drain;
        logic [WIDTH-1:0] d;
        bit ok;
        d = {16{8'h11}};
        set_req(1'b0, 32'h100, d);
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %0b want 1", cpu_ack); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL wr_count got %0d want 1", count); end
        checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL wr_no_mem got %0b want 0", mem_enable); end
        cpu_enable = 1'b0;
        tick();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %0b want 0", cpu_ack); end
        wait_mem(ok);
        checks++; if (!ok) begin errors++; $display("FAIL drain_start got timeout want mem_enable"); end
        checks++; if (mem_rw !== 1'b0) begin errors++; $display("FAIL drain_rw got %0b want 0", mem_rw); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL drain_addr got %h want 00000100", mem_addr); end
        checks++; if (mem_data_in !== d) begin errors++; $display("FAIL drain_data got %h want %h", mem_data_in, d); end
        tick();
        checks++; if (mem_enable !== 1'b1) begin errors++; $display("FAIL drain_hold got %0b want 1", mem_enable); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %0b want 1", empty); end
        checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL drain_mem_off got %0b want 0", mem_enable); end
    endtask

    task automatic test_read_forward;
        logic [WIDTH-1:0] d;
        bit ok;
        d = {4{32'hD1D1_0200}};
        set_req(1'b0, 32'h200, d);
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL fwd_wr_ack got %0b want 1", cpu_ack); end
        cpu_enable = 1'b0;
        tick();
        set_req(1'b1, 32'h204, '0);
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL fwd_rd_ack got %0b want 1", cpu_ack); end
        checks++; if (cpu_data_out !== d) begin errors++; $display("FAIL fwd_rd_data got %h want %h", cpu_data_out, d); end
        checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL fwd_no_mem got %0b want 0", mem_enable); end
        cpu_enable = 1'b0;
        drain_all(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fwd_drain got timeout want empty"); end
    endtask

    task automatic test_full_stall;
        logic [WIDTH-1:0] d5;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b0, 32'(i * 16), {4{32'(i + 1)}});
            tick();
            checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL fill_ack%0d got %0b want 1", i, cpu_ack); end
            cpu_enable = 1'b0;
            tick();
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
        d5 = {4{32'h0000_0555}};
        set_req(1'b0, 32'h040, d5);
        tick();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL full_noack got %0b want 0", cpu_ack); end
        checks++; if (mem_enable !== 1'b1) begin errors++; $display("FAIL full_drain got %0b want 1", mem_enable); end
        checks++; if (mem_addr !== 32'h000) begin errors++; $display("FAIL full_drain_addr got %h want 0", mem_addr); end
        checks++; if (mem_data_in !== {4{32'h1}}) begin errors++; $display("FAIL full_drain_data got %h want %h", mem_data_in, {4{32'h1}}); end
        tick();
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL full_wait got %0b want 0", cpu_ack); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_dequeue got %0d want 3", count); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL full_ack_early got %0b want 0", cpu_ack); end
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL full_accept got %0b want 1", cpu_ack); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_recount got %0d want 4", count); end
        cpu_enable = 1'b0;
        tick();
        wait_mem(ok);
        checks++; if (mem_addr !== 32'h010) begin errors++; $display("FAIL full_order got %h want 00000010", mem_addr); end
        drain_all(ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_drain_all got timeout want empty"); end
    endtask

    task automatic test_read_miss;
        logic [WIDTH-1:0] rd;
        bit ok;
        rd = {4{32'hCAFE_0500}};
        for (int i = 0; i < 2; i++) begin
            set_req(1'b0, 32'h600 + 32'(i * 16), {4{32'hA0 + 32'(i)}});
            tick();
            cpu_enable = 1'b0;
            tick();
        end
        set_req(1'b1, 32'h500, '0);
        tick();
        checks++; if (mem_enable !== 1'b1) begin errors++; $display("FAIL miss_mem_en got %0b want 1", mem_enable); end
        checks++; if (mem_rw !== 1'b1) begin errors++; $display("FAIL miss_rw got %0b want 1", mem_rw); end
        checks++; if (mem_addr !== 32'h500) begin errors++; $display("FAIL miss_addr got %h want 00000500", mem_addr); end
        tick();
        mem_data_out = rd;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        mem_data_out = '0;
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL miss_ack got %0b want 1", cpu_ack); end
        checks++; if (cpu_data_out !== rd) begin errors++; $display("FAIL miss_data got %h want %h", cpu_data_out, rd); end
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL miss_count got %0d want 2", count); end
        checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL miss_mem_off got %0b want 0", mem_enable); end
        cpu_enable = 1'b0;
        drain_all(ok);
        checks++; if (!ok) begin errors++; $display("FAIL miss_drain got timeout want empty"); end
    endtask

    task automatic test_coalesce;
        logic [WIDTH-1:0] d1, d2;
        bit ok;
        d1 = {4{32'h0000_3001}};
        d2 = {4{32'h0000_3002}};
        set_req(1'b0, 32'h300, d1);
        tick();
        cpu_enable = 1'b0;
        tick();
        set_req(1'b0, 32'h300, d2);
        tick();
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL coal_ack got %0b want 1", cpu_ack); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL coal_count got %0d want 1", count); end
        cpu_enable = 1'b0;
        tick();
        wait_mem(ok);
        checks++; if (!ok) begin errors++; $display("FAIL coal_drain got timeout want mem_enable"); end
        checks++; if (mem_data_in !== d2) begin errors++; $display("FAIL coal_data got %h want %h", mem_data_in, d2); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL coal_single got %0b want 1", empty); end
    endtask

    task automatic test_reset_abort;
        bit ok;
        bit seen_ack;
        set_req(1'b0, 32'h700, {4{32'h0000_0777}});
        tick();
        cpu_enable = 1'b0;
        tick();
        wait_mem(ok);
        checks++; if (!ok || mem_rw !== 1'b0) begin errors++; $display("FAIL abort_drain got en=%0b rw=%0b want en=1 rw=0", mem_enable, mem_rw); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL abort_mem_en got %0b want 0", mem_enable); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL abort_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL abort_empty got %0b want 1", empty); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cpu_ack || mem_enable) seen_ack = 1'b1;
            tick();
        end
        checks++; if (seen_ack !== 1'b0) begin errors++; $display("FAIL abort_late_ack got activity=%0b want 0", seen_ack); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL abort_final_count got %0d want 0", count); end
    endtask

    initial begin
        reset        = 1'b1;
        cpu_enable   = 1'b0;
        cpu_rw       = 1'b0;
        cpu_addr     = '0;
        cpu_data_in  = '0;
        mem_data_out = '0;
        mem_ack      = 1'b0;
        test_reset();
        test_write_drain();
        test_read_forward();
        test_full_stall();
        test_read_miss();
        test_coalesce();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Posted-write buffer between the CPU-side memory port (arbiter output) and main memory.
- Writes are accepted into a small FIFO and acknowledged immediately, then drained to memory in the background.
- Reads are served first. A read whose line is pending in the buffer is forwarded from the buffer.
- Removes write-back latency from the D-cache miss path while keeping memory coherent for read-after-write.

Parameters:
- WIDTH, `MEMORY_WIDTH (128): line width in bits of every data port.
- DEPTH, 4: number of buffer entries. Power of two, at least 2.
- OFFSET_BITS, 4: low address bits ignored for line matching. Equals log2(WIDTH/8).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- cpu_enable  in  1  request valid; held with addr/rw/data until cpu_ack.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_addr  in  32  byte address of the line.
- cpu_data_in  in  WIDTH  write data.
- cpu_data_out  out  WIDTH  read data; valid in the cpu_ack cycle.
- cpu_ack  out  1  one-cycle completion pulse.
- mem_enable  out  1  memory request valid.
- mem_rw  out  1  1 = read, 0 = write.
- mem_addr  out  32  line address to memory, with offset bits forced to 0.
- mem_data_in  out  WIDTH  write data to memory.
- mem_data_out  in  WIDTH  read data from memory; valid with mem_ack.
- mem_ack  in  1  memory completion pulse.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- empty  out  1  count == 0.

Behaviour:
- Storage: DEPTH entries, each holding a valid bit, tag (cpu_addr[31:OFFSET_BITS]) and data.
  - Circular FIFO with head/tail pointers that wrap modulo DEPTH.
- Reset values:
  - All valid bits cleared, head = tail = 0, count = 0, empty = 1.
  - cpu_ack = 0, cpu_data_out = 0.
  - mem_enable = 0, mem_rw = 1, mem_addr = 0, mem_data_in = 0.
  - FSM = IDLE.
- Reset mid-transaction aborts immediately:
  - mem_enable = 0 the following cycle.
  - Buffered writes are discarded.
  - A mem_ack arriving after reset is ignored.
- FSM states: IDLE, MEM_RD, MEM_WR, ACK.
- CPU write in IDLE:
  - Tag matches a valid entry that is not the head currently being drained: overwrite that entry's data (coalesce). count unchanged.
  - Else, if count < DEPTH: allocate at tail, tail+1, count+1.
  - Either case: go to ACK. cpu_ack pulses the next cycle, so write latency = 1 cycle.
  - Else (full): no ack. The request stays pending until a drain frees a slot.
- CPU read in IDLE:
  - Tag hits a valid entry: cpu_data_out = newest matching entry's data. Go to ACK, latency 1 cycle, no memory access.
  - Miss: go to MEM_RD with mem_enable=1, mem_rw=1, mem_addr = line address.
  - On mem_ack: latch mem_data_out into cpu_data_out, drop mem_enable, go to ACK.
- ACK: cpu_ack=1 for exactly one cycle, then IDLE.
  - cpu_enable is ignored during ACK, since the CPU removes its request after the ack.
- Drain:
  - In IDLE with count > 0 and no acceptable CPU request: go to MEM_WR with mem_rw=0, mem_addr/mem_data_in from head.
  - On mem_ack: invalidate head, head+1, count-1, return to IDLE.
- Priority in IDLE:
  1. Read (hit or miss).
  2. Write that can be accepted.
  3. Drain.
  - A write to a full buffer forces a drain.
- A CPU request arriving during MEM_WR waits. A memory transaction is never aborted, except by reset.
- Coalesce with the draining head is forbidden; a new entry is allocated instead, so the newest-match rule keeps reads correct.
- Memory-side handshake:
  - mem_enable, mem_rw, mem_addr and mem_data_in stay stable from assertion until mem_ack.
  - mem_enable is low for at least one cycle between transactions.
- count and empty update in the cycle after the enqueue or dequeue edge.
  - Simultaneous enqueue and dequeue cannot occur because the FSM is single-threaded.

Test Plan:
- Reset, then write A=0x100 with data 0x11..11 → cpu_ack 1 cycle later; count=1; no mem_enable until the CPU goes idle; drain issues mem_addr=0x100, mem_rw=0; after mem_ack, count=0 and empty=1.
- Write 0x200 with data D1, then read 0x204 → cpu_ack 1 cycle after the read request; cpu_data_out=D1; mem_enable stays 0 during the read.
- Fill the 4 entries (0x000, 0x010, 0x020, 0x030), then write 0x040 → no ack; drain of 0x000 starts; 1 cycle after that mem_ack, the write is accepted and count=4.
- Read miss 0x500 while 2 entries are pending → MEM_RD is issued before any drain; cpu_data_out=mem_data_out; count stays 2.
- Two writes to 0x300 (D1, then D2) while no drain is in progress → count=1; the single drain writes D2.
- Assert reset during MEM_WR → mem_enable=0 next cycle; count=0; a late mem_ack produces no cpu_ack.
